// File: rtl/contador_param.sv
// Parameterised up/down counter with a built-in prescaler, wrap/saturate modes and tick/tc pulses.
// Optional macro CONTADOR_SYNC_EN adds 2-flop input synchronizers and load edge detection.
module contador_param #(
  parameter int    WIDTH     = 8,
  parameter int    DIV_COUNT = 5000000,
  parameter longint MAX_VAL  = (longint'(1) << WIDTH) - 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             ud,
  input  logic             sat,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tick,
  output logic             tc
);

  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("contador_param: WIDTH must be 1..32");
  end
  if (DIV_COUNT < 1) begin : g_bad_div
    $error("contador_param: DIV_COUNT must be >= 1");
  end
  if (MAX_VAL < 1 || MAX_VAL > ((longint'(1) << WIDTH) - 1)) begin : g_bad_max
    $error("contador_param: MAX_VAL must be within 1..2**WIDTH-1");
  end

  localparam int PW = (DIV_COUNT > 1) ? $clog2(DIV_COUNT) : 1;
  localparam logic [PW-1:0]    PRE_LAST = PW'(DIV_COUNT - 1);
  localparam logic [WIDTH-1:0] MAX      = WIDTH'(MAX_VAL);

  logic          en_i, ud_i, sat_i, load_i;
  logic [PW-1:0] pre_cnt;
  logic          step;

`ifdef CONTADOR_SYNC_EN
  logic [1:0] en_s, ud_s, sat_s, load_s;
  logic       load_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_s   <= '0;
      ud_s   <= '0;
      sat_s  <= '0;
      load_s <= '0;
      load_d <= 1'b0;
    end else begin
      en_s   <= {en_s[0], en};
      ud_s   <= {ud_s[0], ud};
      sat_s  <= {sat_s[0], sat};
      load_s <= {load_s[0], load};
      load_d <= load_s[1];
    end
  end

  assign en_i   = en_s[1];
  assign ud_i   = ud_s[1];
  assign sat_i  = sat_s[1];
  assign load_i = load_s[1] & ~load_d;
`else
  assign en_i   = en;
  assign ud_i   = ud;
  assign sat_i  = sat;
  assign load_i = load;
`endif

  assign step = en_i && (pre_cnt == PRE_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count   <= '0;
      pre_cnt <= '0;
      tick    <= 1'b0;
      tc      <= 1'b0;
    end else if (load_i) begin
      count   <= (load_val > MAX) ? MAX : load_val;
      pre_cnt <= '0;
      tick    <= 1'b0;
      tc      <= 1'b0;
    end else if (en_i) begin
      pre_cnt <= step ? '0 : pre_cnt + PW'(1);
      tick    <= step;
      tc      <= 1'b0;
      if (step) begin
        // Boundary steps either wrap or hold, and both raise tc
        if (ud_i) begin
          if (count >= MAX) begin
            count <= sat_i ? MAX : '0;
            tc    <= 1'b1;
          end else begin
            count <= count + WIDTH'(1);
          end
        end else begin
          if (count == '0) begin
            count <= sat_i ? '0 : MAX;
            tc    <= 1'b1;
          end else begin
            count <= count - WIDTH'(1);
          end
        end
      end
    end else begin
      tick <= 1'b0;
      tc   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_contador_param.sv
// Directed bench for contador_param (WIDTH=4, DIV_COUNT=4, MAX_VAL=9) against an arithmetic model.
module tb_contador_param;

  localparam int WIDTH = 4;
  localparam int DIV   = 4;
  localparam int MAXV  = 9;

  logic             clk = 1'b0;
  logic             rst_n, en, ud, sat, load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic             tick, tc;

  int tests = 0;
  int fails = 0;

  contador_param #(.WIDTH(WIDTH), .DIV_COUNT(DIV), .MAX_VAL(MAXV)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .ud(ud), .sat(sat),
    .load(load), .load_val(load_val), .count(count), .tick(tick), .tc(tc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Model: counts enabled cycles since the last step/load; a step moves count by +/-1,
  // leaving 0..MAXV either wraps or clamps and always flags tc.
  int m_count = 0, m_since = 0, nxt;
  bit m_tick = 0, m_tc = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_count = 0; m_since = 0; m_tick = 0; m_tc = 0;
    end else if (load) begin
      m_count = (int'(load_val) > MAXV) ? MAXV : int'(load_val);
      m_since = 0; m_tick = 0; m_tc = 0;
    end else if (en) begin
      m_since++;
      m_tick = 0; m_tc = 0;
      if (m_since == DIV) begin
        m_since = 0;
        m_tick  = 1;
        nxt = m_count + (ud ? 1 : -1);
        if (nxt < 0 || nxt > MAXV) begin
          m_tc = 1;
          nxt  = sat ? m_count : (nxt + MAXV + 1) % (MAXV + 1);
        end
        m_count = nxt;
      end
    end else begin
      m_tick = 0; m_tc = 0;
    end
  end

  always @(negedge clk) begin
    chk("model_count", count, m_count);
    chk("model_tick", tick, m_tick);
    chk("model_tc", tc, m_tc);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; ud = 1'b1; sat = 1'b0; load = 1'b0; load_val = '0;
    cyc(2);
    chk("reset_count", count, 0);
    chk("reset_tick", tick, 0);
    chk("reset_tc", tc, 0);

    // 1: wrap-up count 0..9,0
    rst_n = 1'b1; en = 1'b1;
    cyc(4);  chk("t1_first_step", count, 1); chk("t1_first_tick", tick, 1);
    cyc(32); chk("t1_at9", count, 9); chk("t1_no_tc", tc, 0);
    cyc(4);  chk("t1_wrap0", count, 0); chk("t1_wrap_tc", tc, 1);
    cyc(1);  chk("t1_tc_gone", tc, 0); chk("t1_tick_gone", tick, 0);

    // 2: down-wrap from 0
    ud = 1'b0;
    cyc(3);  chk("t2_down_wrap", count, 9); chk("t2_tc", tc, 1);
    cyc(4);  chk("t2_down8", count, 8); chk("t2_no_tc", tc, 0);

    // 3: saturate at 9
    load = 1'b1; load_val = 4'd9;
    cyc(1);  chk("t3_loaded", count, 9);
    load = 1'b0; ud = 1'b1; sat = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(4); chk("t3_sat_hold", count, 9); chk("t3_sat_tc", tc, 1);
    end
    ud = 1'b0;
    cyc(4);  chk("t3_down8", count, 8); chk("t3_down_tc", tc, 0);

    // 4: clamped load, then mid-period load
    ud = 1'b1; load = 1'b1; load_val = 4'd12;
    cyc(1);  chk("t4_clamp", count, 9);
    load = 1'b0;
    cyc(2);
    load = 1'b1; load_val = 4'd5;
    cyc(1);  chk("t4_load5", count, 5);
    load = 1'b0;
    cyc(3);  chk("t4_wait", count, 5); chk("t4_no_tick", tick, 0);
    cyc(1);  chk("t4_step6", count, 6); chk("t4_tick", tick, 1);

    // 5: freeze with pre_cnt=2
    cyc(2);
    en = 1'b0;
    cyc(10); chk("t5_frozen", count, 6); chk("t5_tick0", tick, 0); chk("t5_tc0", tc, 0);
    en = 1'b1;
    cyc(1);  chk("t5_one_more", count, 6);
    cyc(1);  chk("t5_step7", count, 7); chk("t5_tick", tick, 1);

    // 6: asynchronous reset between edges
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_count", count, 0);
    chk("t6_async_tick", tick, 0);
    chk("t6_async_tc", tc, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(3);  chk("t6_hold0", count, 0);
    cyc(1);  chk("t6_resume1", count, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
